muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for MUL, UMULH, UDIV and SDIV, which the single-cycle ALU cannot do in one cycle.
- Sits beside the ALU in EX. The decode/ALU-control path asserts start with a 2-bit operation select.
- The block iterates one bit per cycle through a shared 64-bit adder/subtractor, then returns the result.
- While busy it holds the pipeline with a stall output.

---
 rtl/muldiv_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/UMULH/UDIV/SDIV sequencer: one bit per cycle through a shared adder.
// Optional MULDIV_EARLY_EXIT_EN: multiplies exit CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero
);

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpUmulh = 2'b01;
  localparam logic [1:0] OpSdiv  = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] opd_q, opd_d;    // multiplicand or divisor magnitude
  logic [DATA_WIDTH-1:0] hi_q, hi_d;      // product high half or partial remainder
  logic [DATA_WIDTH-1:0] lo_q, lo_d;      // multiplier/product low half or dividend/quotient
  logic                  neg_q, neg_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, done_q;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
`endif

  logic [DATA_WIDTH+1:0]   add_x, add_y, add_s;
  logic [DATA_WIDTH-1:0]   hi_it, lo_it, a_mag, b_mag, fix_res;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    is_sdiv, last_iter;

  // Shared adder: hi + (lo[0] ? multiplicand : 0) for multiply, trial subtract for divide.
  always_comb begin
    if (op_q[1]) begin
      add_x = {1'b0, hi_q, lo_q[DATA_WIDTH-1]};
      add_y = ~{2'b00, opd_q};
    end else begin
      add_x = {2'b00, hi_q};
      add_y = {2'b00, (lo_q[0] ? opd_q : '0)};
    end
    add_s = add_x + add_y + {{(DATA_WIDTH+1){1'b0}}, op_q[1]};
  end

  always_comb begin
    if (op_q[1]) begin
      hi_it = add_s[DATA_WIDTH+1] ? {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]}
                                  : add_s[DATA_WIDTH-1:0];
      lo_it = {lo_q[DATA_WIDTH-2:0], ~add_s[DATA_WIDTH+1]};
    end else begin
      hi_it = add_s[DATA_WIDTH:1];
      lo_it = {add_s[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  assign is_sdiv   = (op == OpSdiv);
  assign a_mag     = (is_sdiv && a[DATA_WIDTH-1]) ? ('0 - a) : a;
  assign b_mag     = (is_sdiv && b[DATA_WIDTH-1]) ? ('0 - b) : b;
  assign last_iter = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
`ifdef MULDIV_EARLY_EXIT_EN
    // An early exit leaves the product short of DATA_WIDTH - cnt right shifts.
    prod = {hi_q, lo_q} >> (CNT_WIDTH'(DATA_WIDTH) - cnt_q);
`else
    prod = {hi_q, lo_q};
`endif
    unique case (op_q)
      OpMul:   fix_res = prod[DATA_WIDTH-1:0];
      OpUmulh: fix_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
      default: fix_res = neg_q ? ('0 - lo_q) : lo_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    result_d = result_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_EARLY_EXIT_EN
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d  = op;
          cnt_d = '0;
          hi_d  = '0;
          neg_d = is_sdiv && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
          dbz_d = op[1] && (b == '0);
          opd_d = op[1] ? b_mag : a;
          lo_d  = op[1] ? a_mag : b;
`ifdef MULDIV_EARLY_EXIT_EN
          mplier_d = b;
`endif
          if (op[1] && (b == '0)) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
`ifdef MULDIV_EARLY_EXIT_EN
          if (!op_q[1] && (mplier_q == '0)) begin
            state_d = StFix;
          end else begin
            hi_d     = hi_it;
            lo_d     = lo_it;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            mplier_d = mplier_q >> 1;
            if (last_iter) state_d = StFix;
          end
`else
          hi_d  = hi_it;
          lo_d  = lo_it;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_iter) state_d = StFix;
`endif
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
`ifdef MULDIV_EARLY_EXIT_EN
      mplier_q <= mplier_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign stall       = (start && (state_q == StIdle) && !flush) ||
                       (state_q == StCalc) || (state_q == StFix);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against a
// reference model, and hand-written timing, flush and reset sequences.
module tb_muldiv_sequencer;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [1:0]    op;
  logic [DW-1:0] a, b, result;
  logic          busy, stall, done, dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a, b, res;
    logic          dbz;
  } vec_t;
  typedef struct {
    logic [DW-1:0] res;
    logic          dbz;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] last_res = '0;
  vec_t          vecs[14];

  muldiv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .result     (result),
    .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge; every done pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("div_by_zero", dbz, e.dbz);
        last_res = e.res;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [DW-1:0] x, y, r, input logic z);
    exp_t e;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e.res = r;
    e.dbz = z;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] x, y, r, input logic z);
    step();
    issue(o, x, y, r, z);
    tick();
    step();
    start = 1'b0;
    tick();
    wait_done(200);
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] o, input logic [DW-1:0] x, y);
    logic [2*DW-1:0] p;
    logic [DW-1:0]   mx, my, q;
    p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    case (o)
      2'b00:   return p[DW-1:0];
      2'b01:   return p[2*DW-1:DW];
      2'b10:   return (y == '0) ? '0 : x / y;
      default: begin
        if (y == '0) return '0;
        mx = x[DW-1] ? ('0 - x) : x;
        my = y[DW-1] ? ('0 - y) : y;
        q  = mx / my;
        return (x[DW-1] ^ y[DW-1]) ? ('0 - q) : q;
      end
    endcase
  endfunction

  // Number of CALC cycles the sequencer spends on an operation.
  function automatic int calc_cycles(input logic [1:0] o, input logic [DW-1:0] y);
    int len = 0;
    for (int i = 0; i < DW; i++) if (y[i]) len = i + 1;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) return (len + 1 > DW) ? DW : len + 1;
`else
    if (len < 0 || o > 2'b11) return 0;
`endif
    return DW;
  endfunction

  initial begin
    logic [127:0] bv, sv, dv, eb, es, ed;
    logic [1:0]   ro;
    logic [DW-1:0] ra, rb;
    int nc;

    vecs[0]  = '{2'b00, 64'd3, 64'd3, 64'd9, 1'b0};
    vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0};
    vecs[2]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[3]  = '{2'b10, 64'd100, 64'd7, 64'd14, 1'b0};
    vecs[4]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[5]  = '{2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1'b0};
    vecs[6]  = '{2'b11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[7]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 1'b0};
    vecs[8]  = '{2'b10, 64'd7, 64'd100, 64'd0, 1'b0};
    vecs[9]  = '{2'b00, 64'd123, 64'd0, 64'd0, 1'b0};
    vecs[10] = '{2'b01, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1'b0};
    vecs[11] = '{2'b11, 64'd7, 64'd0, 64'd0, 1'b1};
    vecs[12] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[13] = '{2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    step();
    step();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_dbz", dbz, 0);
    check("rst_stall", stall, 0);
    step();
    rst = 1'b0;
    tick();

    // MUL 7*6 cycle-by-cycle: index 0 is the cycle start is presented.
    nc = calc_cycles(2'b00, 64'd6);
    bv = '0; sv = '0; dv = '0; eb = '0; es = '0; ed = '0;
    step();
    issue(2'b00, 64'd7, 64'd6, 64'd42, 1'b0);
    for (int i = 0; i < nc + 4; i++) begin
      if (i > 0) begin
        step();
        start = 1'b0;
      end
      tick();
      bv[i] = busy; sv[i] = stall; dv[i] = done;
      eb[i] = (i >= 1) && (i <= nc + 2);
      es[i] = (i <= nc + 1);
      ed[i] = (i == nc + 2);
    end
    check("mul_busy_trace", bv, eb);
    check("mul_stall_trace", sv, es);
    check("mul_done_trace", dv, ed);

    // Divide by zero completes in one cycle.
    bv = '0; sv = '0; dv = '0;
    step();
    issue(2'b10, 64'd5, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        step();
        start = 1'b0;
      end
      tick();
      bv[i] = busy; sv[i] = stall; dv[i] = done;
    end
    check("dz_busy_trace", bv, 128'b010);
    check("dz_stall_trace", sv, 128'b001);
    check("dz_done_trace", dv, 128'b010);
    step();
    tick();
    check("dz_flag_held", dbz, 1);
    check("dz_result_held", result, 0);

    for (int i = 0; i < 14; i++) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);

    for (int k = 0; k < 8; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 2 == 1) rb = rb >> $urandom_range(0, 63);
      run_op(ro, ra, rb, model(ro, ra, rb), ro[1] && (rb == '0));
    end

    // Flush mid-CALC, restart at cycle 12, ignored start pulses during CALC.
    step();
    op = 2'b00; a = '1; b = '1; start = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      step();
      start = 1'b0;
      flush = (i == 10);
      if (i == 12) issue(2'b00, 64'd11, 64'd13, 64'd143, 1'b0);
      if (i == 17 || i == 18) begin
        op = 2'b10; a = 64'd1; b = '0; start = 1'b1;
      end
      tick();
      if (i == 11) begin
        check("flush_busy", busy, 0);
        check("flush_result", result, last_res);
      end
      if (i == 12) check("restart_stall", stall, 1);
    end
    step();
    start = 1'b0;
    tick();
    wait_done(200);
    for (int i = 0; i < 4; i++) begin
      step();
      tick();
    end

    // Flush and start together: request dropped.
    step();
    op = 2'b00; a = 64'd2; b = 64'd2; start = 1'b1; flush = 1'b1;
    tick();
    check("flush_start_stall", stall, 0);
    step();
    start = 1'b0; flush = 1'b0;
    tick();
    check("flush_start_busy", busy, 0);

    // Reset during CALC.
    step();
    op = 2'b00; a = '1; b = '1; start = 1'b1;
    tick();
    for (int i = 1; i <= 21; i++) begin
      step();
      start = 1'b0;
      rst = (i == 20);
      tick();
    end
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_dbz", dbz, 0);
    check("midrst_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
